// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions.
//   - WIDTH_MIN / WIDTH_MAX : legal operand widths for the serial datapaths
//   - state_t               : FSM encoding for the serial subtractor
//                             (ST_IDLE, ST_RUN, ST_DONE, 2 bits)
package arith_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bit_serial_subtractor_if.sv
// Handshake and data bundle for bit_serial_subtractor.
//   start      : request a subtraction (master -> slave)
//   a, b       : minuend / subtrahend, WIDTH bits (master -> slave)
//   diff       : (a - b) mod 2^WIDTH (slave -> master)
//   borrow_out : 1 iff unsigned a < b (slave -> master)
//   ovf        : two's-complement overflow (slave -> master)
//   busy       : operation in progress (slave -> master)
//   done       : one-cycle result-valid pulse (slave -> master)
interface bit_serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b,
    input  diff, borrow_out, ovf, busy, done
  );

  modport slave (
    input  start, a, b,
    output diff, borrow_out, ovf, busy, done
  );

endinterface

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell: computes a - b - bin.
//   a, b, bin : operand bits and incoming borrow
//   d         : difference bit
//   bout      : outgoing borrow
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a, or when they are equal and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial two's-complement subtractor, diff = a - b, one bit per clock,
// LSB first, using a single full_subtractor cell over WIDTH cycles.
//   clk : clock, all state updates on rising edge
//   rst : synchronous active-high reset
//   bus : bit_serial_subtractor_if.slave (start/a/b in; diff/borrow_out/
//         ovf/busy/done out)
// Latency is WIDTH cycles from the accepting edge; a new operation can be
// accepted from DONE, giving a WIDTH+1 cycle back-to-back period.
module bit_serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  bit_serial_subtractor_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  generate
    if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
      $error("bit_serial_subtractor: WIDTH out of range");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  // Only WIDTH-1 result bits are ever stored: the final bit goes straight
  // from the cell into diff on the completing edge.
  logic [WIDTH-2:0] sd_q, sd_d;
  logic             bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-2:0] sd_shifted;

  full_subtractor u_cell (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (bin_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Result shift register moves right; the new difference bit enters at
  // the top.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_sd_shift
      if (gi == WIDTH - 2) begin : g_top
        assign sd_shifted[gi] = cell_d;
      end else begin : g_mid
        assign sd_shifted[gi] = sd_q[gi+1];
      end
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sd_d     = sd_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        sd_d  = sd_shifted;
        bin_d = cell_bout;
        if (cnt_q == CNT_LAST) begin
          diff_d   = {cell_d, sd_q};
          borrow_d = cell_bout;
          // On the last bit the cell inputs are exactly the operand MSBs.
          ovf_d    = (sa_q[0] ^ sb_q[0]) & (cell_d ^ sa_q[0]);
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sd_q     <= sd_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.ovf        = ovf_q;
  assign bus.busy       = (state_q == ST_RUN);
  assign bus.done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_bit_serial_subtractor.sv
module tb_bit_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bit_serial_subtractor_if #(.WIDTH(W)) bus ();

  bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands with start high for one accepting edge; returns #1
  // after that edge.
  task automatic do_start(input logic [7:0] aa, input logic [7:0] bb);
    bus.start = 1'b1;
    bus.a     = aa;
    bus.b     = bb;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Advance until done is seen (bounded); n = edges taken, bc = samples
  // with busy high before done.
  task automatic wait_done(output int n, output int bc, output bit ok);
    n  = 0;
    bc = 0;
    ok = 1'b0;
    while (n < 40) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) bc++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.diff, bus.borrow_out, bus.ovf, bus.busy, bus.done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got diff=%h bo=%b ovf=%b busy=%b done=%b expected all 0",
               bus.diff, bus.borrow_out, bus.ovf, bus.busy, bus.done);
    end
  endtask

  task automatic test_simple();
    int n, bc;
    bit ok;
    do_start(8'h05, 8'h03);
    wait_done(n, bc, ok);
    checks++;
    if (!ok || n != 8) begin
      failures++;
      $display("FAIL simple_latency got %0d (done_seen=%0b) expected 8", n, ok);
    end
    checks++;
    if (bc != 8) begin
      failures++;
      $display("FAIL simple_busy_cycles got %0d expected 8", bc);
    end
    checks++;
    if ({bus.diff, bus.borrow_out, bus.ovf} !== {8'h02, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL simple_result got diff=%h bo=%b ovf=%b expected diff=02 bo=0 ovf=0",
               bus.diff, bus.borrow_out, bus.ovf);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL simple_busy_with_done got %b expected 0", bus.busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.diff !== 8'h02) begin
      failures++;
      $display("FAIL simple_done_pulse got done=%b diff=%h expected done=0 diff=02",
               bus.done, bus.diff);
    end
    $display("simple: 05-03 diff=%h bo=%b ovf=%b latency=%0d", bus.diff, bus.borrow_out, bus.ovf, n);
  endtask

  task automatic test_directed(input string name, input logic [7:0] aa, input logic [7:0] bb,
                               input logic [7:0] ed, input logic eb, input logic eo);
    int n, bc;
    bit ok;
    do_start(aa, bb);
    wait_done(n, bc, ok);
    checks++;
    if (!ok || {bus.diff, bus.borrow_out, bus.ovf} !== {ed, eb, eo}) begin
      failures++;
      $display("FAIL %s got diff=%h bo=%b ovf=%b done_seen=%0b expected diff=%h bo=%b ovf=%b",
               name, bus.diff, bus.borrow_out, bus.ovf, ok, ed, eb, eo);
    end
    $display("%s: %h-%h diff=%h bo=%b ovf=%b", name, aa, bb, bus.diff, bus.borrow_out, bus.ovf);
  endtask

  task automatic test_sweep();
    int n, bc, nops, nbad;
    bit ok;
    logic [7:0] ev;
    logic       eb, eo;
    nops = 0;
    nbad = 0;
    for (int ai = 0; ai < 256; ai += 17) begin
      for (int bi = 0; bi < 256; bi += 15) begin
        ev = 8'(ai - bi);
        eb = (ai < bi);
        eo = (ai[7] != bi[7]) && (ev[7] != ai[7]);
        do_start(8'(ai), 8'(bi));
        wait_done(n, bc, ok);
        nops++;
        checks++;
        if (!ok || {bus.diff, bus.borrow_out, bus.ovf} !== {ev, eb, eo}) begin
          failures++;
          nbad++;
          $display("FAIL sweep a=%h b=%h got diff=%h bo=%b ovf=%b expected diff=%h bo=%b ovf=%b",
                   8'(ai), 8'(bi), bus.diff, bus.borrow_out, bus.ovf, ev, eb, eo);
        end
      end
    end
    $display("sweep: %0d operand pairs, %0d wrong", nops, nbad);
  endtask

  task automatic test_start_in_run();
    int n, bc, extra;
    bit ok;
    do_start(8'h10, 8'h01);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(n, bc, ok);
    checks++;
    if (!ok || {bus.diff, bus.borrow_out, bus.ovf} !== {8'h0F, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL start_in_run_result got diff=%h bo=%b ovf=%b done_seen=%0b expected diff=0f bo=0 ovf=0",
               bus.diff, bus.borrow_out, bus.ovf, ok);
    end
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL start_in_run_second_op got %0d active cycles expected 0", extra);
    end
    $display("start_in_run: diff=%h extra_active=%0d", bus.diff, extra);
  endtask

  task automatic test_reset_mid();
    int n, bc, extra;
    bit ok;
    do_start(8'hAA, 8'h55);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({bus.diff, bus.borrow_out, bus.ovf, bus.busy, bus.done} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got diff=%h bo=%b ovf=%b busy=%b done=%b expected all 0",
               bus.diff, bus.borrow_out, bus.ovf, bus.busy, bus.done);
    end
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL reset_mid_resumed got %0d active cycles expected 0", extra);
    end
    do_start(8'hAA, 8'h55);
    wait_done(n, bc, ok);
    checks++;
    if (!ok || {bus.diff, bus.borrow_out, bus.ovf} !== {8'h55, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid_restart got diff=%h bo=%b ovf=%b done_seen=%0b expected diff=55 bo=0 ovf=1",
               bus.diff, bus.borrow_out, bus.ovf, ok);
    end
    $display("reset_mid: restart AA-55 diff=%h bo=%b ovf=%b", bus.diff, bus.borrow_out, bus.ovf);
  endtask

  task automatic test_back_to_back();
    int n, bc, gap;
    bit ok, ok2;
    bus.start = 1'b1;
    bus.a     = 8'h20;
    bus.b     = 8'h10;
    @(posedge clk);
    #1;
    wait_done(n, bc, ok);
    checks++;
    if (!ok || {bus.diff, bus.borrow_out, bus.ovf} !== {8'h10, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_first got diff=%h bo=%b ovf=%b done_seen=%0b expected diff=10 bo=0 ovf=0",
               bus.diff, bus.borrow_out, bus.ovf, ok);
    end
    bus.a = 8'h00;
    bus.b = 8'h01;
    gap = 0;
    ok2 = 1'b0;
    while (gap < 40) begin
      @(posedge clk);
      #1;
      gap++;
      if (bus.done) begin
        ok2 = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (!ok2 || gap != 9) begin
      failures++;
      $display("FAIL b2b_spacing got %0d (done_seen=%0b) expected 9", gap, ok2);
    end
    checks++;
    if ({bus.diff, bus.borrow_out, bus.ovf} !== {8'hFF, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL b2b_second got diff=%h bo=%b ovf=%b expected diff=ff bo=1 ovf=0",
               bus.diff, bus.borrow_out, bus.ovf);
    end
    $display("back_to_back: spacing=%0d second diff=%h bo=%b", gap, bus.diff, bus.borrow_out);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    test_reset();
    test_simple();
    test_directed("borrow", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    test_directed("ovf_neg_minus_pos", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    test_directed("ovf_pos_minus_neg", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    test_sweep();
    test_start_in_run();
    test_reset_mid();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
